reg_readback: RTL and testbench
===============================

# reg_readback

Read-side counterpart of the dual-writer control register. Two independent readers request the 32-bit register contents over a level-request / pulse-acknowledge handshake. The block arbitrates round-robin between them, issues one fetch to the register source, and waits for the returned word. It delivers the word, or an error word on timeout, to the granted reader. It sits between the register bank's read port and two consumers, typically a bus slave and a debug/monitor path.

## Interface
- DATA_W, 32, width of the register word
- TIMEOUT, 16, maximum WAIT cycles before an error response (≥1)
- ERR_WORD, 32'hDEAD_BEEF, data returned on timeout
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- rd1_req_i  in  1  reader 1 request, level, held until ack
- rd2_req_i  in  1  reader 2 request, level, held until ack
- rd1_ack_o  out  1  reader 1 acknowledge, one-cycle pulse
- rd2_ack_o  out  1  reader 2 acknowledge, one-cycle pulse
- rd1_data_o  out  DATA_W  data for reader 1, held until next rd1 ack
- rd2_data_o  out  DATA_W  data for reader 2, held until next rd2 ack
- rd1_err_o  out  1  timeout flag for reader 1, updated with rd1 ack
- rd2_err_o  out  1  timeout flag for reader 2, updated with rd2 ack
- src_req_o  out  1  one-cycle fetch strobe to the register source
- src_valid_i  in  1  source returns data this cycle
- src_data_i  in  DATA_W  source data, valid with src_valid_i
- busy_o  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered or Moore-decoded from state.
- IDLE: if any request is high, latch the grant owner and go to ISSUE. Otherwise stay in IDLE.
- Arbitration: if only one reader requests, that reader wins. If both request, the reader not served last wins. After reset, reader 1 wins the first tie.
- ISSUE: src_req_o = 1 for exactly this cycle. Clear the timeout counter. Go to WAIT.
- WAIT, priority order:
  - src_valid_i = 1: capture src_data_i, err = 0, go to RESP.
  - counter = TIMEOUT-1: capture ERR_WORD, err = 1, go to RESP.
  - otherwise: increment the counter.
- Counter width is $clog2(TIMEOUT+1). It never wraps.
- src_valid_i arriving on the final WAIT cycle wins over the timeout.
- src_valid_i outside WAIT is ignored, including late returns after a timeout.
- RESP: the owner's ack_o = 1 for one cycle. The owner's data_o and err_o take the captured values at entry to RESP and hold afterwards. Update the last-served pointer. Go to IDLE.
- The other reader's data_o and err_o never change on a response that is not its own.
- Handshake rule: a requester deasserts req at the clock edge where it samples ack = 1. A req withdrawn before ack is not supported. The grant is latched in IDLE, and later req changes are ignored until RESP.
- A request held across RESP by the non-owner is served next. Starvation is bounded to one transaction.
- Reset (asynchronous, any state, including mid-WAIT):
  - state returns to IDLE
  - all outputs go to 0, including data_o and err_o
  - counter cleared
  - last-served pointer set so that reader 1 wins the next tie
  - any in-flight fetch is abandoned

## Timing
- Request sampled high in IDLE at edge 0: ISSUE in cycle 1 (src_req_o high), WAIT from cycle 2.
- src_valid_i high in cycle 2 gives RESP in cycle 3 (ack high). Minimum latency from req sampled to ack is 3 cycles.
- Source returning at WAIT cycle k (k = 1..TIMEOUT) gives ack at cycle 2+k.
- Timeout: ack with err = 1 at cycle 2+TIMEOUT.
- Back-to-back: IDLE occupies one cycle between transactions, so the best-case throughput is 1 response per 4 cycles.
- busy_o is high from cycle 1 through the RESP cycle inclusive.

## Test plan
- Reset values: hold rst_i low mid-WAIT → busy_o, both ack/data/err, and src_req_o all read 0 immediately (asynchronous). After release, the FSM is in IDLE.
- Single read: rd1_req_i = 1, source returns 32'h1234_5678 in the first WAIT cycle → src_req_o pulse in cycle 1, rd1_ack_o in cycle 3, rd1_data_o = 32'h1234_5678, rd1_err_o = 0. rd2 outputs remain 0.
- Tie and round-robin: both requests high from reset, source answers A, then B → reader 1 receives A first, reader 2 then receives B. Repeat the tie → reader 1 wins again (last served was reader 2).
- Timeout: rd2_req_i = 1, no src_valid_i → rd2_ack_o at cycle 2+16 = 18, rd2_data_o = 32'hDEAD_BEEF, rd2_err_o = 1. A late src_valid_i at cycle 20 is ignored.
- Boundary: src_valid_i on WAIT cycle 16 exactly with data 32'hCAFE_0001 → normal response, err = 0, data 32'hCAFE_0001.
- Hold behaviour: reader 1 is served 32'hAAAA_AAAA, then reader 2 is served 32'h5555_5555 → rd1_data_o stays 32'hAAAA_AAAA throughout.

Source files
------------

// File: rtl/reg_readback.sv
// reg_readback: read-side arbiter for the shared control register.
// Two level-request readers are served round-robin; each grant issues a
// single fetch strobe to the register source. The block then waits for the
// returned word, or substitutes ERR_WORD after TIMEOUT wait cycles. The
// result is delivered to the granted reader with a one-cycle ack.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no transaction; arbitrate and latch owner when a req is high
// ST_ISSUE | fetch strobe to source for one cycle, timeout counter cleared
// ST_WAIT  | waiting for src_valid_i, counting toward the timeout
// ST_RESP  | ack pulse to owner, data/err already updated, update last-served
module reg_readback #(
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       TIMEOUT  = 16,
    parameter logic [DATA_W-1:0] ERR_WORD = 32'hDEAD_BEEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rd1_req_i,
    input  logic              rd2_req_i,
    output logic              rd1_ack_o,
    output logic              rd2_ack_o,
    output logic [DATA_W-1:0] rd1_data_o,
    output logic [DATA_W-1:0] rd2_data_o,
    output logic              rd1_err_o,
    output logic              rd2_err_o,
    output logic              src_req_o,
    input  logic              src_valid_i,
    input  logic [DATA_W-1:0] src_data_i,
    output logic              busy_o
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Reader identity encoding: 0 = reader 1, 1 = reader 2.
    localparam logic RD1 = 1'b0;
    localparam logic RD2 = 1'b1;

    state_t            state_q;
    state_t            state_d;
    logic              owner_q;
    logic              owner_d;
    logic              owner_ld;
    logic              last_q;
    logic              last_ld;
    logic [CNT_W-1:0]  cnt_q;
    logic              cnt_clr;
    logic              cnt_inc;
    logic              cap_ok;
    logic              cap_err;
    logic [DATA_W-1:0] cap_word;
    logic [DATA_W-1:0] rd1_data_q;
    logic [DATA_W-1:0] rd2_data_q;
    logic              rd1_err_q;
    logic              rd2_err_q;

    // State register; reset abandons any in-flight fetch.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode plus the datapath control strobes for each state.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        owner_ld = 1'b0;
        last_ld  = 1'b0;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        cap_ok   = 1'b0;
        cap_err  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rd1_req_i || rd2_req_i) begin
                    owner_ld = 1'b1;
                    state_d  = ST_ISSUE;
                    // On a tie the reader not served last wins.
                    if (rd1_req_i && rd2_req_i) begin
                        owner_d = ~last_q;
                    end else begin
                        owner_d = rd2_req_i ? RD2 : RD1;
                    end
                end
            end
            ST_ISSUE: begin
                cnt_clr = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Source data on the last wait cycle still beats the timeout.
                if (src_valid_i) begin
                    cap_ok  = 1'b1;
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    cap_err = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ST_RESP: begin
                last_ld = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Owner latched once in IDLE; request changes afterwards are ignored.
    // Last-served resets to reader 2 so reader 1 takes the first tie.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            owner_q <= RD1;
            last_q  <= RD2;
        end else begin
            if (owner_ld) begin
                owner_q <= owner_d;
            end
            if (last_ld) begin
                last_q <= owner_q;
            end
        end
    end

    // Wait-cycle counter; stops at CNT_LAST, so it never wraps.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= '0;
        end else if (cnt_inc) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign cap_word = cap_ok ? src_data_i : ERR_WORD;

    // Owner's data/err are written on entry to RESP; the other reader's hold.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd1_data_q <= '0;
            rd1_err_q  <= 1'b0;
            rd2_data_q <= '0;
            rd2_err_q  <= 1'b0;
        end else if (cap_ok || cap_err) begin
            if (owner_q == RD1) begin
                rd1_data_q <= cap_word;
                rd1_err_q  <= cap_err;
            end else begin
                rd2_data_q <= cap_word;
                rd2_err_q  <= cap_err;
            end
        end
    end

    // Moore-decoded handshake outputs.
    assign src_req_o  = (state_q == ST_ISSUE);
    assign busy_o     = (state_q != ST_IDLE);
    assign rd1_ack_o  = (state_q == ST_RESP) && (owner_q == RD1);
    assign rd2_ack_o  = (state_q == ST_RESP) && (owner_q == RD2);
    assign rd1_data_o = rd1_data_q;
    assign rd2_data_o = rd2_data_q;
    assign rd1_err_o  = rd1_err_q;
    assign rd2_err_o  = rd2_err_q;

endmodule

// File: tb/tb_reg_readback.sv
// Directed bench for reg_readback: reset, single read, timeout, boundary,
// data hold, round-robin tie and asynchronous reset mid-transaction.
module tb_reg_readback;

    localparam int TIMEOUT = 16;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        rd1_req_i;
    logic        rd2_req_i;
    logic        rd1_ack_o;
    logic        rd2_ack_o;
    logic [31:0] rd1_data_o;
    logic [31:0] rd2_data_o;
    logic        rd1_err_o;
    logic        rd2_err_o;
    logic        src_req_o;
    logic        src_valid_i;
    logic [31:0] src_data_i;
    logic        busy_o;

    int checks   = 0;
    int failures = 0;
    int lat;

    reg_readback #(
        .DATA_W  (32),
        .TIMEOUT (TIMEOUT),
        .ERR_WORD(32'hDEAD_BEEF)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rd1_req_i  (rd1_req_i),
        .rd2_req_i  (rd2_req_i),
        .rd1_ack_o  (rd1_ack_o),
        .rd2_ack_o  (rd2_ack_o),
        .rd1_data_o (rd1_data_o),
        .rd2_data_o (rd2_data_o),
        .rd1_err_o  (rd1_err_o),
        .rd2_err_o  (rd2_err_o),
        .src_req_o  (src_req_o),
        .src_valid_i(src_valid_i),
        .src_data_i (src_data_i),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    // Called in an IDLE cycle with requests already driven. Source answers on
    // wait cycle k (k = 0 means never). Returns in the RESP cycle with lat set
    // to the cycle number counted from the sampling edge.
    task automatic wait_resp(input int k, input logic [31:0] d, output int lat_o);
        tick;
        lat_o = 1;
        check_eq("issue_strobe", {31'd0, src_req_o}, 32'd1);
        tick;
        lat_o = 2;
        check_eq("strobe_one_cycle", {31'd0, src_req_o}, 32'd0);
        for (int w = 1; w <= TIMEOUT + 2; w++) begin
            if (w == k) begin
                src_valid_i = 1'b1;
                src_data_i  = d;
            end
            tick;
            lat_o       = 2 + w;
            src_valid_i = 1'b0;
            src_data_i  = 32'h0;
            if (rd1_ack_o || rd2_ack_o) break;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i       = 1'b0;
        rd1_req_i   = 1'b0;
        rd2_req_i   = 1'b0;
        src_valid_i = 1'b0;
        src_data_i  = 32'h0;
        #3;
        check_eq("rst_busy", {31'd0, busy_o}, 32'd0);
        check_eq("rst_rd1_data", rd1_data_o, 32'h0);
        check_eq("rst_rd2_data", rd2_data_o, 32'h0);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b1;
        tick;
        tick;

        // Single read by reader 1, answered on the first wait cycle.
        rd1_req_i = 1'b1;
        wait_resp(1, 32'h1234_5678, lat);
        check_eq("single_lat", lat, 32'd3);
        check_eq("single_ack", {31'd0, rd1_ack_o}, 32'd1);
        check_eq("single_data", rd1_data_o, 32'h1234_5678);
        check_eq("single_err", {31'd0, rd1_err_o}, 32'd0);
        check_eq("single_rd2_ack", {31'd0, rd2_ack_o}, 32'd0);
        check_eq("single_rd2_data", rd2_data_o, 32'h0);
        check_eq("single_busy_resp", {31'd0, busy_o}, 32'd1);
        rd1_req_i = 1'b0;
        tick;
        check_eq("single_idle_busy", {31'd0, busy_o}, 32'd0);
        check_eq("single_ack_pulse", {31'd0, rd1_ack_o}, 32'd0);
        check_eq("single_hold", rd1_data_o, 32'h1234_5678);

        // Timeout on reader 2, then a late source return in IDLE.
        rd2_req_i = 1'b1;
        wait_resp(0, 32'h0, lat);
        check_eq("to_lat", lat, 32'd18);
        check_eq("to_ack", {31'd0, rd2_ack_o}, 32'd1);
        check_eq("to_data", rd2_data_o, 32'hDEAD_BEEF);
        check_eq("to_err", {31'd0, rd2_err_o}, 32'd1);
        check_eq("to_rd1_data", rd1_data_o, 32'h1234_5678);
        rd2_req_i = 1'b0;
        tick;
        tick;
        src_valid_i = 1'b1;
        src_data_i  = 32'h1111_1111;
        tick;
        src_valid_i = 1'b0;
        src_data_i  = 32'h0;
        check_eq("late_busy", {31'd0, busy_o}, 32'd0);
        check_eq("late_ack", {30'd0, rd1_ack_o, rd2_ack_o}, 32'd0);
        check_eq("late_rd2_data", rd2_data_o, 32'hDEAD_BEEF);
        check_eq("late_rd2_err", {31'd0, rd2_err_o}, 32'd1);

        // Source answers on the final wait cycle: data wins over timeout.
        rd1_req_i = 1'b1;
        wait_resp(TIMEOUT, 32'hCAFE_0001, lat);
        check_eq("bnd_lat", lat, 32'd18);
        check_eq("bnd_ack", {31'd0, rd1_ack_o}, 32'd1);
        check_eq("bnd_data", rd1_data_o, 32'hCAFE_0001);
        check_eq("bnd_err", {31'd0, rd1_err_o}, 32'd0);
        rd1_req_i = 1'b0;
        tick;

        // Hold: reader 2's response leaves reader 1's word untouched.
        rd1_req_i = 1'b1;
        wait_resp(2, 32'hAAAA_AAAA, lat);
        check_eq("hold1_lat", lat, 32'd4);
        check_eq("hold1_data", rd1_data_o, 32'hAAAA_AAAA);
        rd1_req_i = 1'b0;
        tick;
        rd2_req_i = 1'b1;
        wait_resp(3, 32'h5555_5555, lat);
        check_eq("hold2_lat", lat, 32'd5);
        check_eq("hold2_ack", {30'd0, rd1_ack_o, rd2_ack_o}, 32'd1);
        check_eq("hold2_data", rd2_data_o, 32'h5555_5555);
        check_eq("hold2_err", {31'd0, rd2_err_o}, 32'd0);
        check_eq("hold2_rd1_data", rd1_data_o, 32'hAAAA_AAAA);
        rd2_req_i = 1'b0;
        tick;
        check_eq("hold_after", rd1_data_o, 32'hAAAA_AAAA);

        // Serve reader 1 so last-served points at reader 1 before reset.
        rd1_req_i = 1'b1;
        wait_resp(1, 32'h0BAD_F00D, lat);
        check_eq("pre_rst_data", rd1_data_o, 32'h0BAD_F00D);
        rd1_req_i = 1'b0;
        tick;

        // Asynchronous reset in the middle of a reader 2 wait.
        rd2_req_i = 1'b1;
        tick;
        tick;
        tick;
        check_eq("midwait_busy", {31'd0, busy_o}, 32'd1);
        rst_i = 1'b0;
        #2;
        check_eq("arst_busy", {31'd0, busy_o}, 32'd0);
        check_eq("arst_src_req", {31'd0, src_req_o}, 32'd0);
        check_eq("arst_acks", {30'd0, rd1_ack_o, rd2_ack_o}, 32'd0);
        check_eq("arst_rd1_data", rd1_data_o, 32'h0);
        check_eq("arst_rd2_data", rd2_data_o, 32'h0);
        check_eq("arst_errs", {30'd0, rd1_err_o, rd2_err_o}, 32'd0);
        rd2_req_i = 1'b0;
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        tick;
        check_eq("arst_idle", {31'd0, busy_o}, 32'd0);

        // Tie after reset: reader 1 first, reader 2 next, reader 1 again.
        rd1_req_i = 1'b1;
        rd2_req_i = 1'b1;
        wait_resp(1, 32'hA0A0_0001, lat);
        check_eq("tie1_lat", lat, 32'd3);
        check_eq("tie1_acks", {30'd0, rd1_ack_o, rd2_ack_o}, 32'd2);
        check_eq("tie1_data", rd1_data_o, 32'hA0A0_0001);
        rd1_req_i = 1'b0;
        tick;
        check_eq("tie_idle_gap", {31'd0, busy_o}, 32'd0);
        wait_resp(1, 32'hB0B0_0002, lat);
        check_eq("tie2_acks", {30'd0, rd1_ack_o, rd2_ack_o}, 32'd1);
        check_eq("tie2_data", rd2_data_o, 32'hB0B0_0002);
        check_eq("tie2_rd1_data", rd1_data_o, 32'hA0A0_0001);
        rd2_req_i = 1'b0;
        tick;
        rd1_req_i = 1'b1;
        rd2_req_i = 1'b1;
        wait_resp(2, 32'hC0C0_0003, lat);
        check_eq("tie3_acks", {30'd0, rd1_ack_o, rd2_ack_o}, 32'd2);
        check_eq("tie3_data", rd1_data_o, 32'hC0C0_0003);
        rd1_req_i = 1'b0;
        tick;
        wait_resp(1, 32'hD0D0_0004, lat);
        check_eq("tie4_acks", {30'd0, rd1_ack_o, rd2_ack_o}, 32'd1);
        check_eq("tie4_data", rd2_data_o, 32'hD0D0_0004);
        rd2_req_i = 1'b0;
        tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
